// File: rtl/i2c_pkg.sv
// Shared types and constants for the codec-programming I2C writer.
// One command becomes a fixed three-byte frame: address+W, register+data MSB, data LSBs.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    ACK,
    STOP
  } state_t;

  typedef logic [1:0] quarter_t;

  localparam logic I2C_WR_BIT    = 1'b0;
  localparam int   BYTES_PER_CMD = 3;
  localparam int   FRAME_BITS    = 8 * BYTES_PER_CMD;

  function automatic logic [FRAME_BITS-1:0] buildFrame(
    input logic [6:0] devAddr,
    input logic [6:0] regAddr,
    input logic [8:0] regData
  );
    return {devAddr, I2C_WR_BIT, regAddr, regData};
  endfunction

endpackage

// File: rtl/quarter_tick.sv
// Divides the I2C-domain clock into quarter-bit ticks; tick_o marks the last
// cycle of each quarter. Clearing restarts a full-length quarter.
module quarter_tick #(
  parameter int QUARTER = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int            CW   = (QUARTER > 1) ? $clog2(QUARTER) : 1;
  localparam logic [CW-1:0] LAST = CW'(QUARTER - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/i2c_codec_writer.sv
// Write-only I2C master: each accepted {reg, data} command becomes one
// START, addr+W, two data bytes, STOP sequence on open-drain SCL/SDA enables.
module i2c_codec_writer
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = 7'h1A,
  parameter int         QUARTER   = 1,
  parameter bit         CHECK_ACK = 1'b1
) (
  input  logic       clk400k,
  input  logic       rst400k,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_reg,
  input  logic [8:0] cmd_data,
  input  logic       sda_i,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       nack
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_CMD - 1);
  localparam int         MSB       = FRAME_BITS - 1;

  state_t          state_q, state_d;
  quarter_t        quarter_q, quarter_d;
  logic [2:0]      bitCnt_q, bitCnt_d;
  logic [1:0]      byteCnt_q, byteCnt_d;
  logic [MSB:0]    shift_q, shift_d;
  logic            ackBit_q, ackBit_d;
  logic            nackSeen_q, nackSeen_d;
  logic            done_q, done_d;
  logic            nack_q, nack_d;
  logic            accept;
  logic            quarterTick;

  assign accept = cmd_valid && (state_q == IDLE);

  quarter_tick #(
    .QUARTER(QUARTER)
  ) u_quarter_tick (
    .clk_i  (clk400k),
    .rst_i  (rst400k),
    .clear_i(accept),
    .tick_o (quarterTick)
  );

  always_comb begin
    state_d    = state_q;
    quarter_d  = quarter_q;
    bitCnt_d   = bitCnt_q;
    byteCnt_d  = byteCnt_q;
    shift_d    = shift_q;
    ackBit_d   = ackBit_q;
    nackSeen_d = nackSeen_q;
    done_d     = 1'b0;
    nack_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d    = START;
          quarter_d  = 2'd0;
          bitCnt_d   = 3'd0;
          byteCnt_d  = 2'd0;
          shift_d    = buildFrame(DEV_ADDR, cmd_reg, cmd_data);
          ackBit_d   = 1'b0;
          nackSeen_d = 1'b0;
        end
      end
      default: begin
        if (quarterTick) begin
          quarter_d = quarter_q + 2'd1;
          // The slave's ACK is taken while SCL is high, just before it drops.
          if ((state_q == ACK) && (quarter_q == 2'd2)) begin
            ackBit_d = sda_i;
          end
          if (quarter_q == 2'd3) begin
            case (state_q)
              START: begin
                state_d  = DATA;
                bitCnt_d = 3'd0;
              end
              DATA: begin
                shift_d = {shift_q[MSB-1:0], 1'b0};
                if (bitCnt_q == 3'd7) begin
                  state_d = ACK;
                end else begin
                  bitCnt_d = bitCnt_q + 3'd1;
                end
              end
              ACK: begin
                if (CHECK_ACK && ackBit_q) begin
                  state_d    = STOP;
                  nackSeen_d = 1'b1;
                end else if (byteCnt_q == LAST_BYTE) begin
                  state_d = STOP;
                end else begin
                  state_d   = DATA;
                  byteCnt_d = byteCnt_q + 2'd1;
                  bitCnt_d  = 3'd0;
                end
              end
              STOP: begin
                state_d = IDLE;
                done_d  = 1'b1;
                nack_d  = nackSeen_q;
              end
              default: begin
                state_d = IDLE;
              end
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk400k) begin
    if (rst400k) begin
      state_q    <= IDLE;
      quarter_q  <= 2'd0;
      bitCnt_q   <= 3'd0;
      byteCnt_q  <= 2'd0;
      shift_q    <= '0;
      ackBit_q   <= 1'b0;
      nackSeen_q <= 1'b0;
      done_q     <= 1'b0;
      nack_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      quarter_q  <= quarter_d;
      bitCnt_q   <= bitCnt_d;
      byteCnt_q  <= byteCnt_d;
      shift_q    <= shift_d;
      ackBit_q   <= ackBit_d;
      nackSeen_q <= nackSeen_d;
      done_q     <= done_d;
      nack_q     <= nack_d;
    end
  end

  // Line drive is decoded from registered state only, so SDA moves solely at q0.
  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    case (state_q)
      START: begin
        sda_oe = (quarter_q == 2'd2) || (quarter_q == 2'd3);
        scl_oe = (quarter_q == 2'd3);
      end
      DATA: begin
        scl_oe = (quarter_q == 2'd0) || (quarter_q == 2'd3);
        sda_oe = ~shift_q[MSB];
      end
      ACK: begin
        scl_oe = (quarter_q == 2'd0) || (quarter_q == 2'd3);
      end
      STOP: begin
        scl_oe = (quarter_q == 2'd0);
        sda_oe = (quarter_q == 2'd0) || (quarter_q == 2'd1);
      end
      default: begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
      end
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign nack      = nack_q;

endmodule

// File: tb/tb_i2c_codec_writer.sv
// Randomized bench for i2c_codec_writer: open-drain bus, a bit-level slave
// that collects bytes and ACK/NACKs, and a frame/latency reference model.
module tb_i2c_codec_writer;

  localparam logic [6:0] DEV_ADDR_TB = 7'h1A;

  logic       clk400k = 1'b0;
  logic       rst400k;
  logic       cmd_valid;
  logic       cmd_valid3;
  logic [6:0] cmd_reg;
  logic [8:0] cmd_data;
  logic       cmd_ready, scl_oe, sda_oe, busy, done, nack;
  logic       cmd_ready3, scl_oe3, sda_oe3, busy3, done3, nack3;
  logic       sclBus, sdaBus;
  logic       slaveLow = 1'b0;

  int checks = 0;
  int errors = 0;

  // Slave model state
  int         nackAt = -1;
  int         rxCount = 0;
  logic [7:0] rxByte = 8'h00;
  logic [7:0] rxQ[$];
  int         startCnt = 0;
  int         stopCnt = 0;
  logic       sclPrev = 1'b1;
  logic       sdaPrev = 1'b1;

  always #5 clk400k = ~clk400k;

  assign sclBus = ~scl_oe;
  assign sdaBus = ~(sda_oe | slaveLow);

  i2c_codec_writer #(
    .DEV_ADDR (DEV_ADDR_TB),
    .QUARTER  (1),
    .CHECK_ACK(1'b1)
  ) dut (
    .clk400k  (clk400k),
    .rst400k  (rst400k),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_reg  (cmd_reg),
    .cmd_data (cmd_data),
    .sda_i    (sdaBus),
    .scl_oe   (scl_oe),
    .sda_oe   (sda_oe),
    .busy     (busy),
    .done     (done),
    .nack     (nack)
  );

  i2c_codec_writer #(
    .DEV_ADDR (DEV_ADDR_TB),
    .QUARTER  (3),
    .CHECK_ACK(1'b1)
  ) dut3 (
    .clk400k  (clk400k),
    .rst400k  (rst400k),
    .cmd_valid(cmd_valid3),
    .cmd_ready(cmd_ready3),
    .cmd_reg  (cmd_reg),
    .cmd_data (cmd_data),
    .sda_i    (1'b0),
    .scl_oe   (scl_oe3),
    .sda_oe   (sda_oe3),
    .busy     (busy3),
    .done     (done3),
    .nack     (nack3)
  );

  // Bus-level slave: START/STOP are SDA edges with SCL high, data sampled on SCL rise,
  // ACK driven from the SCL fall after the 8th bit until the fall after the 9th clock.
  always @(sclBus or sdaBus) begin
    if (sclPrev === 1'b1 && sclBus === 1'b1 && sdaPrev === 1'b1 && sdaBus === 1'b0) begin
      startCnt++;
      rxCount  = 0;
      slaveLow = 1'b0;
      rxQ.delete();
    end else if (sclPrev === 1'b1 && sclBus === 1'b1 && sdaPrev === 1'b0 && sdaBus === 1'b1) begin
      stopCnt++;
    end else if (sclPrev === 1'b0 && sclBus === 1'b1) begin
      if (rxCount < 8) rxByte = {rxByte[6:0], sdaBus};
      rxCount++;
      if (rxCount == 8) rxQ.push_back(rxByte);
      else if (rxCount == 9) rxCount = 0;
    end else if (sclPrev === 1'b1 && sclBus === 1'b0) begin
      if (rxCount == 8) slaveLow = ((int'(rxQ.size()) - 1) != nackAt);
      else if (rxCount == 0) slaveLow = 1'b0;
    end
    sclPrev = sclBus;
    sdaPrev = ~(sda_oe | slaveLow);
  end

  function automatic int refLatency(input int quarter, input int nBytes);
    return quarter * (4 + 36 * nBytes + 4);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Presents a command and returns #1 after the edge that accepted it.
  task automatic applyStimulus(input logic [6:0] r, input logic [8:0] d, input bit keepValid);
    logic readyBefore;
    bit   accepted;
    accepted  = 1'b0;
    cmd_reg   = r;
    cmd_data  = d;
    cmd_valid = 1'b1;
    for (int i = 0; i < 500 && !accepted; i++) begin
      readyBefore = cmd_ready;
      @(posedge clk400k);
      #1;
      if (readyBefore) accepted = 1'b1;
    end
    if (!accepted) checkOutput("accept timeout", 32'd0, 32'd1);
    if (!keepValid) begin
      cmd_valid = 1'b0;
      cmd_reg   = 7'($urandom);
      cmd_data  = 9'($urandom);
    end
  endtask

  // Called #1 after the accepting edge; follows one transfer to its done pulse.
  task automatic checkTransfer(input string tag, input logic [6:0] r, input logic [8:0] d, input int nackIdx);
    logic [7:0] expB[3];
    int nBytes;
    int expLat;
    int cycles;
    int s0;
    int p0;
    bit seen;
    nBytes  = (nackIdx < 0) ? 3 : nackIdx + 1;
    expLat  = refLatency(1, nBytes);
    expB[0] = {DEV_ADDR_TB, 1'b0};
    expB[1] = {r, d[8]};
    expB[2] = d[7:0];
    s0      = startCnt;
    p0      = stopCnt;
    cycles  = 0;
    seen    = 1'b0;
    nackAt  = nackIdx;
    while (!seen && cycles < expLat + 50) begin
      @(posedge clk400k);
      #1;
      cycles++;
      if (cycles == 1) begin
        checkOutput({tag, " busy after accept"}, 32'(busy), 32'd1);
        checkOutput({tag, " ready after accept"}, 32'(cmd_ready), 32'd0);
      end
      if (done === 1'b1) seen = 1'b1;
    end
    checkOutput({tag, " done cycle"}, seen ? 32'(cycles) : 32'hFFFF_FFFF, 32'(expLat));
    checkOutput({tag, " nack"}, 32'(nack), (nackIdx >= 0) ? 32'd1 : 32'd0);
    checkOutput({tag, " busy at done"}, 32'(busy), 32'd0);
    checkOutput({tag, " ready at done"}, 32'(cmd_ready), 32'd1);
    checkOutput({tag, " byte count"}, 32'(rxQ.size()), 32'(nBytes));
    for (int i = 0; i < nBytes && i < rxQ.size(); i++) begin
      checkOutput($sformatf("%s byte%0d", tag, i), 32'(rxQ[i]), 32'(expB[i]));
    end
    checkOutput({tag, " starts"}, 32'(startCnt - s0), 32'd1);
    checkOutput({tag, " stops"}, 32'(stopCnt - p0), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [6:0] r;
    logic [8:0] d;
    int pick;
    int doneCount;
    int highRun;
    int runs;
    int badRuns;
    int cycles;
    bit seenLow;
    bit seen;

    rst400k    = 1'b1;
    cmd_valid  = 1'b0;
    cmd_valid3 = 1'b0;
    cmd_reg    = 7'h00;
    cmd_data   = 9'h000;
    repeat (3) @(posedge clk400k);
    #1;
    checkOutput("reset scl_oe", 32'(scl_oe), 32'd0);
    checkOutput("reset sda_oe", 32'(sda_oe), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset nack", 32'(nack), 32'd0);
    checkOutput("reset ready", 32'(cmd_ready), 32'd1);
    rst400k = 1'b0;
    @(posedge clk400k);
    #1;

    // Directed: plain write, address NACK, all-ones payload
    applyStimulus(7'h0F, 9'h000, 1'b0);
    checkTransfer("s1", 7'h0F, 9'h000, -1);
    r = 7'($urandom);
    d = 9'($urandom);
    applyStimulus(r, d, 1'b0);
    checkTransfer("s2 nack addr", r, d, 0);
    applyStimulus(7'h7F, 9'h1FF, 1'b0);
    checkTransfer("s3 ones", 7'h7F, 9'h1FF, -1);

    // Randomized commands and NACK positions
    for (int k = 0; k < 8; k++) begin
      r    = 7'($urandom);
      d    = 9'($urandom);
      pick = int'($urandom_range(0, 4));
      applyStimulus(r, d, 1'b0);
      checkTransfer($sformatf("rand%0d", k), r, d, (pick >= 3) ? -1 : pick);
    end

    // Back-to-back: second command waits on a held valid
    r = 7'($urandom);
    d = 9'($urandom);
    applyStimulus(r, d, 1'b1);
    cmd_reg  = 7'h55;
    cmd_data = 9'h0AA;
    checkTransfer("s4 first", r, d, -1);
    @(posedge clk400k);
    #1;
    cmd_valid = 1'b0;
    checkOutput("s4 second busy", 32'(busy), 32'd1);
    checkOutput("s4 second start q0 scl", 32'(scl_oe), 32'd0);
    checkOutput("s4 second start q0 sda", 32'(sda_oe), 32'd0);
    checkOutput("s4 done single pulse", 32'(done), 32'd0);
    checkTransfer("s4 second", 7'h55, 9'h0AA, -1);

    // Reset during B1 bit 3
    nackAt = -1;
    applyStimulus(7'($urandom), 9'($urandom), 1'b0);
    repeat (52) @(posedge clk400k);
    #1;
    checkOutput("s5 busy before reset", 32'(busy), 32'd1);
    rst400k = 1'b1;
    @(posedge clk400k);
    #1;
    checkOutput("s5 scl_oe", 32'(scl_oe), 32'd0);
    checkOutput("s5 sda_oe", 32'(sda_oe), 32'd0);
    checkOutput("s5 busy", 32'(busy), 32'd0);
    checkOutput("s5 ready", 32'(cmd_ready), 32'd1);
    rst400k   = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk400k);
      #1;
      if (done === 1'b1) doneCount++;
    end
    checkOutput("s5 no done", 32'(doneCount), 32'd0);

    // QUARTER=3 instance: latency and SCL high time per bit
    r = 7'($urandom);
    d = 9'($urandom);
    cmd_reg  = r;
    cmd_data = d;
    checkOutput("s6 ready", 32'(cmd_ready3), 32'd1);
    cmd_valid3 = 1'b1;
    @(posedge clk400k);
    #1;
    cmd_valid3 = 1'b0;
    cycles  = 0;
    seen    = 1'b0;
    highRun = 0;
    runs    = 0;
    badRuns = 0;
    seenLow = 1'b0;
    while (!seen && cycles < refLatency(3, 3) + 50) begin
      @(posedge clk400k);
      #1;
      cycles++;
      if (done3 === 1'b1) begin
        seen = 1'b1;
      end else if (scl_oe3 === 1'b0) begin
        highRun++;
      end else begin
        if (seenLow && highRun > 0) begin
          runs++;
          if (highRun != 6) badRuns++;
        end
        highRun = 0;
        seenLow = 1'b1;
      end
    end
    checkOutput("s6 done cycle", seen ? 32'(cycles) : 32'hFFFF_FFFF, 32'(refLatency(3, 3)));
    checkOutput("s6 nack", 32'(nack3), 32'd0);
    checkOutput("s6 busy at done", 32'(busy3), 32'd0);
    checkOutput("s6 scl high runs", 32'(runs), 32'd27);
    checkOutput("s6 scl high not 6", 32'(badRuns), 32'd0);
    checkOutput("s6 sda released", 32'(sda_oe3), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
